// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbiter that lets an instruction cache and a data
// cache share one downstream line port (L2 / physical memory). A grant holds
// until the downstream completion pulse arrives; transfers cannot be aborted.
module cache_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    // Instruction-cache side
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    // Data-cache side
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    // Downstream side
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       last_d;       // 1 when the most recent grant went to the data cache
    logic       last_d_next;

    logic i_pending;
    logic d_pending;

    assign i_pending = i_read | i_write;
    assign d_pending = d_read | d_write;

    // Choose the next grant; on contention favour whoever was not served last.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave it unassigned and infer a latch.
        state_next  = state;
        last_d_next = last_d;
        case (state)
            IDLE: begin
                if (d_pending && (!i_pending || !last_d)) begin
                    state_next  = GRANT_D;
                    last_d_next = 1'b1;
                end else if (i_pending) begin
                    state_next  = GRANT_I;
                    last_d_next = 1'b0;
                end
            end
            GRANT_I: begin
                if (mem_resp) state_next = IDLE;
            end
            GRANT_D: begin
                if (mem_resp) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and round-robin pointer registers, synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state  <= state_next;
            last_d <= last_d_next;
        end
    end

    // Mirror the granted requester onto the downstream port; quiet when idle.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        case (state)
            GRANT_I: begin
                mem_read    = i_read;
                mem_write   = i_write;
                mem_address = i_address;
                mem_wdata   = i_wdata;
            end
            GRANT_D: begin
                mem_read    = d_read;
                mem_write   = d_write;
                mem_address = d_address;
                mem_wdata   = d_wdata;
            end
            default: ;
        endcase
    end

    // Completion goes only to the granted side; a reset cycle swallows it so a
    // discarded transfer never reports completion.
    assign i_resp = (state == GRANT_I) && mem_resp && !rst;
    assign d_resp = (state == GRANT_D) && mem_resp && !rst;

    // Read data is broadcast; the resp pulse says which side it belongs to.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed bench for cache_arbiter. Stimulus pushes the
// expected completion (which side, which line) into a queue; a monitor pops
// and compares whenever a resp pulse appears.
module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_read = 1'b0, i_write = 1'b0;
    logic [AW-1:0] i_address = '0;
    logic [LW-1:0] i_wdata = '0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0, d_write = 1'b0;
    logic [AW-1:0] d_address = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata = '0;
    logic          mem_resp = 1'b0;

    typedef struct {
        logic          is_d;
        logic [LW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_write(i_write), .i_address(i_address),
        .i_wdata(i_wdata), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; registered state has settled.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: every resp pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (i_resp || d_resp) begin
            if (i_resp && d_resp)
                check("resp_both", 256'({i_resp, d_resp}), 256'b01);
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 256'({i_resp, d_resp}), 256'b0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_d_resp", 256'(d_resp), 256'(e.is_d));
                check("sb_i_resp", 256'(i_resp), 256'(!e.is_d));
                check("sb_rdata", e.is_d ? d_rdata : i_rdata, e.data);
            end
        end
    end

    // Hold synchronous reset for two edges with all requests low.
    task automatic do_reset();
        rst = 1'b1;
        i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
        mem_resp = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Called in the first grant cycle: downstream answers in grant cycle n.
    // Returns in the cycle after the response (arbiter back in IDLE).
    task automatic complete(input int n, input logic is_d, input logic [LW-1:0] line);
        for (int k = 1; k < n; k++) cyc();
        mem_rdata = line;
        exp_q.push_back('{is_d: is_d, data: line});
        mem_resp = 1'b1;
        #1;
        check("resp_same_cycle", 256'({i_resp, d_resp}), is_d ? 256'b01 : 256'b10);
        cyc();
        mem_resp = 1'b0;
        #1;
        check("resp_single", 256'({i_resp, d_resp}), 256'b0);
    endtask

    initial begin
        logic [LW-1:0] line_a5;
        logic [LW-1:0] line_12;
        logic [LW-1:0] line_i;
        line_a5 = {32{8'hA5}};
        line_12 = {8{32'h1234_5678}};
        line_i  = {8{32'hCAFE_F00D}};

        // ---- Reset values, rdata broadcast ----
        do_reset();
        mem_rdata = {16{16'h7E57}};
        #1;
        check("rst_mem_read", 256'(mem_read), 256'b0);
        check("rst_mem_write", 256'(mem_write), 256'b0);
        check("rst_mem_address", 256'(mem_address), 256'b0);
        check("rst_mem_wdata", mem_wdata, 256'b0);
        check("rst_resp", 256'({i_resp, d_resp}), 256'b0);
        check("rst_i_rdata", i_rdata, {16{16'h7E57}});
        check("rst_d_rdata", d_rdata, {16{16'h7E57}});

        // ---- mem_resp in IDLE is ignored ----
        mem_resp = 1'b1;
        #1;
        check("idle_resp_ignored", 256'({i_resp, d_resp}), 256'b0);
        cyc();
        mem_resp = 1'b0;
        #1;
        check("idle_stays_idle", 256'(mem_read), 256'b0);

        // ---- Single data-cache read, response in 4th grant cycle ----
        d_read = 1'b1; d_address = 32'h0000_1000;
        #1;
        check("d1_not_yet", 256'(mem_read), 256'b0);
        cyc();
        check("d1_mem_read", 256'(mem_read), 256'b1);
        check("d1_mem_write", 256'(mem_write), 256'b0);
        check("d1_mem_address", 256'(mem_address), 256'h1000);
        complete(4, 1'b1, line_a5);
        check("d1_idle_after", 256'(mem_read), 256'b0);
        d_read = 1'b0;

        // ---- Continuous contention: D, I, D, I ----
        do_reset();
        i_read = 1'b1; i_address = 32'h0000_0400;
        d_read = 1'b1; d_address = 32'h0000_8800;
        for (int g = 0; g < 4; g++) begin
            logic is_d;
            is_d = (g % 2 == 0);
            cyc();
            check("rr_mem_read", 256'(mem_read), 256'b1);
            check("rr_mem_address", 256'(mem_address), is_d ? 256'h8800 : 256'h0400);
            complete(2, is_d, is_d ? line_a5 : line_i);
            check("rr_idle_gap", 256'(mem_read), 256'b0);
        end
        i_read = 1'b0; d_read = 1'b0;

        // ---- D write, I arrives mid-grant and is isolated until M+2 ----
        do_reset();
        d_write = 1'b1; d_address = 32'h0000_2040; d_wdata = line_12;
        cyc();
        i_read = 1'b1; i_address = 32'hDEAD_0000; i_wdata = line_i;
        #1;
        check("dw_mem_write", 256'(mem_write), 256'b1);
        check("dw_no_i_read", 256'(mem_read), 256'b0);
        check("dw_mem_address", 256'(mem_address), 256'h2040);
        check("dw_mem_wdata", mem_wdata, line_12);
        complete(3, 1'b1, '0);
        d_write = 1'b0;
        check("dw_idle_m1", 256'({mem_read, mem_write}), 256'b0);
        cyc();
        check("dw_i_grant_m2", 256'(mem_read), 256'b1);
        check("dw_i_address", 256'(mem_address), 256'hDEAD_0000);
        check("dw_i_wdata", mem_wdata, line_i);
        complete(1, 1'b0, line_i);
        i_read = 1'b0;

        // ---- Read+write pass-through, then requester drops mid-grant ----
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_3000; d_wdata = line_a5;
        cyc();
        cyc();
        check("rw_both", 256'({mem_read, mem_write}), 256'b11);
        d_read = 1'b0; d_write = 1'b0;
        cyc();
        check("drop_mirror", 256'({mem_read, mem_write}), 256'b00);
        check("drop_address", 256'(mem_address), 256'h3000);
        complete(2, 1'b1, line_12);

        // ---- Reset during GRANT_I discards the transfer ----
        i_read = 1'b1; i_address = 32'h0000_5000;
        cyc();
        check("ri_granted", 256'(mem_read), 256'b1);
        rst = 1'b1;
        cyc();
        check("ri_idle", 256'(mem_read), 256'b0);
        check("ri_no_resp", 256'(i_resp), 256'b0);
        i_read = 1'b0;
        cyc();
        rst = 1'b0;
        mem_resp = 1'b1;
        #1;
        check("ri_late_resp", 256'({i_resp, d_resp}), 256'b0);
        cyc();
        mem_resp = 1'b0;
        #1;
        check("ri_still_idle", 256'(mem_read), 256'b0);

        cyc();
        check("sb_drained", 256'(exp_q.size()), 256'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter LINE_WIDTH, default 256: cache-line data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32: physical address width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_read  input  1  instruction-cache line read request.
REQ-006 i_write  input  1  instruction-cache line write request (normally 0).
REQ-007 i_address  input  ADDR_WIDTH  instruction-cache line address.
REQ-008 i_wdata  input  LINE_WIDTH  instruction-cache write line.
REQ-009 i_rdata  output  LINE_WIDTH  read line returned to the instruction cache.
REQ-010 i_resp  output  1  one-cycle completion pulse to the instruction cache.
REQ-011 d_read, d_write, d_address, d_wdata, d_rdata, d_resp  same directions/widths/meaning as REQ-005..010, for the data cache.
REQ-012 mem_read  output  1  downstream (L2/pmem) read request.
REQ-013 mem_write  output  1  downstream write request.
REQ-014 mem_address  output  ADDR_WIDTH  downstream line address.
REQ-015 mem_wdata  output  LINE_WIDTH  downstream write line.
REQ-016 mem_rdata  input  LINE_WIDTH  downstream read line.
REQ-017 mem_resp  input  1  downstream one-cycle completion pulse.

Function
REQ-018 FSM states SHALL be IDLE, GRANT_I, GRANT_D; the state register SHALL be the only sequential element besides the round-robin pointer last_d (1 bit).
REQ-019 A requester is pending when its read or write is high; requesters hold request, address and wdata stable until their resp.
REQ-020 IDLE: only d pending -> GRANT_D; only i pending -> GRANT_I; none -> IDLE.
REQ-021 IDLE, both pending: last_d=1 -> GRANT_I; last_d=0 -> GRANT_D (round-robin).
REQ-022 Entering GRANT_D SHALL set last_d=1; entering GRANT_I SHALL set last_d=0.
REQ-023 GRANT_x: mem_read/mem_write/mem_address/mem_wdata SHALL combinationally mirror requester x's signals; the other requester SHALL have no effect on mem_*.
REQ-024 IDLE: mem_read=0, mem_write=0; mem_address and mem_wdata SHALL be 0.
REQ-025 GRANT_x with mem_resp=1: x_resp=1 in that same cycle; next state IDLE.
REQ-026 GRANT_x with mem_resp=0: remain in GRANT_x; x_resp=0.
REQ-027 x_resp SHALL never assert outside GRANT_x; the non-granted resp SHALL stay 0 even if mem_resp=1.
REQ-028 i_rdata and d_rdata SHALL both equal mem_rdata at all times; validity is indicated only by the respective resp.
REQ-029 Latency: request first seen in IDLE at cycle N -> mem_* asserted at N+1; mem_resp at cycle M -> x_resp at M, IDLE at M+1, next grant earliest at M+2.
REQ-030 Requester dropping its request while granted: SHALL stay in GRANT_x until mem_resp (downstream transfers cannot be aborted); mem_* keep mirroring x.
REQ-031 Requester asserting read and write together: mem_read and mem_write SHALL both pass through unchanged (no arbitration inside a requester).
REQ-032 mem_resp while in IDLE SHALL be ignored: no resp pulse, no state change.

Reset
REQ-033 Edge with rst=1: state=IDLE, last_d=0, regardless of current state or mem_resp.
REQ-034 After reset all outputs SHALL read 0 except i_rdata/d_rdata (= mem_rdata); reset during GRANT_x discards the transfer without any resp pulse.
REQ-035 First contention after reset SHALL grant D.

Verification
REQ-036 Reset, d_read=1, d_address=0x0000_1000, mem_resp at 4th cycle of GRANT_D with mem_rdata=0xA5..A5 -> mem_read=1/mem_address=0x1000 from N+1, d_resp=1 and d_rdata=0xA5..A5 same cycle, i_resp=0.
REQ-037 After reset i_read and d_read both 1 continuously, mem_resp after 2 cycles per grant -> grants alternate D, I, D, I; each resp single-cycle.
REQ-038 d_write=1, d_address=0x0000_2040, d_wdata=0x1234..., i_read=1 raised during GRANT_D -> mem_write=1 with d data only; i granted at M+2.
REQ-039 rst=1 during GRANT_I before mem_resp -> next cycle IDLE, mem_read=0, i_resp never pulses; later mem_resp ignored.
REQ-040 mem_resp=1 with no request pending in IDLE -> i_resp=d_resp=0, state IDLE.
